// File: rtl/adder_rr_scheduler.sv
// rtl/adder_rr_scheduler.sv - round-robin scheduler sharing one external W-bit adder among NREQ requesters
module adder_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_chain,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic              add_cin,
    input  logic [W-1:0]      add_sum,
    input  logic              add_cout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_sum,
    output logic              res_cout,
    output logic [IDW-1:0]    res_id,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    localparam logic [IDW:0]   NREQ_X   = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  owner;
    logic [NREQ-1:0] carry;

    logic [IDW-1:0]  winner;
    logic            any_valid;
    logic [IDW:0]    scan;
    logic [W-1:0]    win_a;
    logic [W-1:0]    win_b;
    logic            win_chain;
    logic            win_carry;
    logic [IDW-1:0]  next_ptr;

    // Scan downward so the last hit (smallest offset from rr_ptr) wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        scan      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (scan >= NREQ_X) begin
                scan = scan - NREQ_X;
            end
            if (req_valid[scan[IDW-1:0]]) begin
                winner    = scan[IDW-1:0];
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        win_a     = '0;
        win_b     = '0;
        win_chain = 1'b0;
        win_carry = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == winner) begin
                win_a     = req_a[i*W +: W];
                win_b     = req_b[i*W +: W];
                win_chain = req_chain[i];
                win_carry = carry[i];
            end
        end
    end

    assign next_ptr  = (owner == LAST_ID) ? '0 : owner + 1'b1;
    assign req_ready = (!rst && state == IDLE && any_valid) ? (ONE_HOT0 << winner) : '0;

    // add_a/add_b/add_cin double as the captured operand registers, so the
    // adder inputs are stable for the entire CALC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            carry     <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_id    <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        add_a   <= win_a;
                        add_b   <= win_b;
                        add_cin <= win_chain & win_carry;
                        owner   <= winner;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    res_sum      <= add_sum;
                    res_cout     <= add_cout;
                    res_id       <= owner;
                    carry[owner] <= add_cout;
                    res_valid    <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        rr_ptr    <= next_ptr;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb/tb_adder_rr_scheduler.sv - self-checking bench for adder_rr_scheduler
module tb_adder_rr_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_chain;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic              add_cin;
    logic [W-1:0]      add_sum;
    logic              add_cout;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_sum;
    logic              res_cout;
    logic [IDW-1:0]    res_id;
    logic              busy;

    adder_rr_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_chain(req_chain),
        .req_ready(req_ready),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // External shared adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic       ch;
        logic [7:0] es;
        logic       ec;
    } vec_t;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic [1:0] id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int oh2id(input logic [3:0] oh);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (oh[i]) r = i;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("res_sum", res_sum, mon_e.sum);
                check("res_cout", res_cout, mon_e.cout);
                check("res_id", res_id, mon_e.id);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    task automatic do_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic ch,
                          input logic [7:0] es, input logic ec, input logic [3:0] others);
        exp_t       e;
        int         n;
        logic [3:0] oh;
        oh = 4'b0001 << id;
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        req_chain[id]    = ch;
        req_valid        = oh | others;
        #1;
        n = 0;
        while (req_ready != oh && n < 10) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("grant", req_ready, oh);
        e.sum = es;
        e.cout = ec;
        e.id = id[1:0];
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = '0;
        check("calc_busy", busy, 1);
        check("calc_ready", req_ready, 0);
        check("calc_res_valid", res_valid, 0);
        @(posedge clk);
        #1;
        check("latency_res_valid", res_valid, 1);
        drain("drained");
        check("idle_busy", busy, 0);
    endtask

    vec_t vecs[8];
    exp_t e;
    int   g_id[6];
    int   g_cyc[6];
    int   ng;
    int   n;

    initial begin
        vecs[0] = '{1, 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[3] = '{2, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[4] = '{3, 8'h10, 8'h20, 1'b1, 8'h30, 1'b0};
        vecs[5] = '{2, 8'h01, 8'h01, 1'b1, 8'h03, 1'b0};
        vecs[6] = '{3, 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
        vecs[7] = '{3, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_chain = '0;
        res_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        req_valid = 4'hF;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_add", {add_a, add_b, add_cin}, 0);
        check("rst_res", {res_sum, res_cout, res_id}, 0);
        req_valid = '0;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].ch, vecs[i].es, vecs[i].ec, 4'b0000);
        end

        // Backpressure: hold res_ready low for 5 RESP cycles with another requester waiting.
        req_a[16 +: 8] = 8'h11;
        req_b[16 +: 8] = 8'h22;
        req_chain[2] = 1'b0;
        req_valid = 4'b0100;
        #1;
        check("bp_grant", req_ready, 4'b0100);
        e.sum = 8'h33; e.cout = 1'b0; e.id = 2'd2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_a[0 +: 8] = 8'h01;
        req_b[0 +: 8] = 8'h02;
        req_chain[0] = 1'b0;
        req_valid = 4'b0001;
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_res_valid", res_valid, 1);
            check("bp_res_sum", res_sum, 8'h33);
            check("bp_res_id", res_id, 2);
            check("bp_req_ready", req_ready, 0);
        end
        res_ready = 1'b1;
        e.sum = 8'h03; e.cout = 1'b0; e.id = 2'd0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check("bp_release_valid", res_valid, 0);
        check("bp_next_grant", req_ready, 4'b0001);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain("bp_drained");

        // Fairness: all requesters held valid from rr_ptr=0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = 8'((i + 1) * 16);
            req_b[i*8 +: 8] = 8'(i + 1);
        end
        req_chain = '0;
        for (int k = 0; k < 6; k++) begin
            e.sum = 8'(((k % 4) + 1) * 17);
            e.cout = 1'b0;
            e.id = 2'(k % 4);
            sb.push_back(e);
        end
        req_valid = 4'hF;
        #1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            if (req_ready != 0) begin
                g_id[ng] = oh2id(req_ready);
                g_cyc[ng] = c;
                ng++;
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        check("fair_grants", ng, 6);
        for (int k = 0; k < ng; k++) begin
            check("fair_order", g_id[k], k % 4);
            if (k > 0) check("fair_spacing", g_cyc[k] - g_cyc[k-1], 3);
        end
        drain("fair_drained");

        // Reset during CALC must clear carry flags and rr_ptr.
        do_req(1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 4'b0000);
        req_a[8 +: 8] = 8'hAA;
        req_b[8 +: 8] = 8'h55;
        req_chain[1] = 1'b0;
        req_valid = 4'b0010;
        #1;
        check("rc_grant", req_ready, 4'b0010);
        @(posedge clk);
        #1;
        req_valid = '0;
        check("rc_add", {add_a, add_b}, 16'hAA55);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rc_busy", busy, 0);
        check("rc_res_valid", res_valid, 0);
        check("rc_add_zero", {add_a, add_b, add_cin}, 0);
        check("rc_res_zero", {res_sum, res_cout, res_id}, 0);
        n = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (res_valid) n++;
        end
        check("rc_no_result", n, 0);
        do_req(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 4'b1000);
        do_req(1, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 4'b0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
- Shares one external combinational 8-bit adder, the carry-select adder datapath, between NREQ requesters.
- Arbitration is round-robin. Operands are captured, the adder is driven for one settle cycle, and the result is returned with a valid/ready handshake tagged with the requester ID.
- Keeps a per-requester carry flag so a requester can chain multi-byte additions across transactions, LSB byte first.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 8, operand width; must match the shared adder width
IDW, 2, width of requester ID; must equal clog2(NREQ)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  NREQ  per-requester request valid
req_a  input  NREQ*W  operand A; requester i occupies bits [i*W +: W]
req_b  input  NREQ*W  operand B; same packing as req_a
req_chain  input  NREQ  1 = use the stored carry of requester i as cin; 0 = cin is 0
req_ready  output  NREQ  one-hot accept pulse; the request completes when valid & ready
add_a  output  W  operand A to the shared adder
add_b  output  W  operand B to the shared adder
add_cin  output  1  carry-in to the shared adder
add_sum  input  W  sum from the shared adder
add_cout  input  1  carry-out from the shared adder
res_valid  output  1  result available
res_ready  input  1  downstream accepts the result
res_sum  output  W  captured sum
res_cout  output  1  captured carry-out
res_id  output  IDW  ID of the requester that owns the result
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE, rr_ptr=0, all carry flags=0.
  - add_a, add_b, add_cin, res_sum, res_cout, res_id = 0.
  - res_valid=0, req_ready=0, busy=0.
  - Reset in any state aborts the operation; any in-flight result is discarded.
- States: IDLE, CALC, RESP.
- IDLE:
  - If any req_valid is set, the winner is the first set bit searching from rr_ptr upward with wrap to 0.
  - req_ready[winner]=1 combinationally in this cycle only.
  - At the edge: op_a/op_b are loaded from the winner's slice; op_cin = req_chain[winner] ? carry[winner] : 0; owner=winner; go to CALC.
  - If no request is valid, stay in IDLE and drive req_ready=0.
- CALC:
  - add_a/add_b/add_cin are driven from the op registers. These outputs are registered and stable for the whole cycle, which absorbs the adder gate delay.
  - At the edge: res_sum=add_sum, res_cout=add_cout, res_id=owner, carry[owner]=add_cout; go to RESP.
- RESP:
  - res_valid=1; res_sum, res_cout and res_id are held stable.
  - On res_valid & res_ready at the edge: rr_ptr=(owner+1) mod NREQ, go to IDLE, res_valid=0 next cycle.
  - No new request is accepted while in RESP; req_ready=0.
- Latency: request accepted at edge T -> res_valid high in cycle T+2. Minimum spacing between accepts is 3 cycles.
- Requesters hold valid and operands stable until ready. Deasserting valid before ready is legal; the request is simply not granted.
- res_ready while res_valid=0 is ignored.
- Arithmetic is modulo 2^W. res_cout is bit W of a+b+cin.
- Carry flags:
  - Updated only when that requester's result is captured in CALC.
  - Other requesters' flags are unaffected.
  - A non-chained request still overwrites its own flag with its new carry-out.
- The add_* outputs hold their last values in IDLE and RESP.
- rr_ptr does not change on reset release or while idle.

Test Plan:
- Single request, ID1: a=0x3C, b=0x5A, chain=0 -> req_ready[1] pulses for 1 cycle; 2 cycles later res_valid=1, res_sum=0x96, res_cout=0, res_id=1.
- Overflow, ID0: 0xFF+0x01, chain=0 -> res_sum=0x00, res_cout=1, carry[0]=1. A follow-up chained request 0x00+0x00 -> res_sum=0x01, res_cout=0.
- Carry isolation: ID2 produces cout=1, then ID3 makes a chained request 0x10+0x20 -> res_sum=0x30, because carry[3]=0.
- Fairness: all four req_valid held high with res_ready=1 -> grant order 0,1,2,3,0,1; each accept 3 cycles apart.
- Backpressure: res_ready held low for 5 cycles in RESP -> res_valid, res_sum and res_id stay stable, all req_ready=0. Accept occurs on the cycle res_ready rises.
- Reset in CALC after accepting 0xAA+0x55 -> next cycle all outputs 0, state IDLE, rr_ptr=0. A chained request from the same ID afterwards uses cin=0.
